// File: rtl/clk_freq_guard.sv
// Clock-health monitor: per-round window check of frequency counts, debounced OK/FAULT per channel.
// Optional min/max tracking is built when CLK_FREQ_GUARD_MINMAX_EN is defined.
module clk_freq_guard #(
  parameter int NUM_CH        = 4,
  parameter int SAMPLE_PERIOD = 125000000,
  parameter int GOOD_COUNT    = 3,
  parameter int BAD_COUNT     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_CH-1:0][31:0] freq,
  input  logic [NUM_CH-1:0][31:0] expected,
  input  logic [31:0]            tol,
  input  logic                   clear_faults,
  output logic [NUM_CH-1:0]      ok,
  output logic                   all_ok,
  output logic [NUM_CH-1:0]      fault_sticky,
  output logic                   irq,
  output logic                   round_done,
  output logic [NUM_CH-1:0][31:0] freq_min,
  output logic [NUM_CH-1:0][31:0] freq_max
);

  localparam int TW   = $clog2(SAMPLE_PERIOD);
  localparam int IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAXC = (GOOD_COUNT > BAD_COUNT) ? GOOD_COUNT : BAD_COUNT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);
  localparam logic [CW-1:0] GOOD_TH   = CW'(GOOD_COUNT);
  localparam logic [CW-1:0] BAD_TH    = CW'(BAD_COUNT);

  // A round occupies NUM_CH+3 cycles after its tick, so a shorter period would overlap rounds.
  if (SAMPLE_PERIOD < NUM_CH + 3) begin : g_period_check
    $error("clk_freq_guard: SAMPLE_PERIOD must be at least NUM_CH+3");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_numch_check
    $error("clk_freq_guard: NUM_CH must be in 1..16");
  end
  if (GOOD_COUNT < 1 || BAD_COUNT < 1) begin : g_count_check
    $error("clk_freq_guard: GOOD_COUNT and BAD_COUNT must be at least 1");
  end

  typedef enum logic [1:0] {RND_IDLE, RND_SNAP, RND_EVAL, RND_FIN} rnd_state_t;
  typedef enum logic [1:0] {CH_UNKNOWN, CH_OK, CH_FAULT} ch_state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt <= '0;
    else if (!enable || tick)  tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + TW'(1);
  end

  rnd_state_t    rnd_state, rnd_next;
  logic [IW-1:0] ch_idx;
  logic          eval_en;

  assign eval_en = (rnd_state == RND_EVAL);

  always_comb begin
    rnd_next = rnd_state;
    case (rnd_state)
      RND_IDLE: if (tick) rnd_next = RND_SNAP;
      RND_SNAP: rnd_next = RND_EVAL;
      RND_EVAL: if (ch_idx == LAST_CH) rnd_next = RND_FIN;
      RND_FIN:  rnd_next = RND_IDLE;
      default:  rnd_next = RND_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_state <= RND_IDLE;
      ch_idx    <= '0;
    end else begin
      rnd_state <= rnd_next;
      if (rnd_state == RND_SNAP) ch_idx <= '0;
      else if (eval_en)          ch_idx <= ch_idx + IW'(1);
    end
  end

  logic [NUM_CH-1:0][31:0] freq_s, exp_s;
  logic [31:0]             tol_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_s <= '0;
      exp_s  <= '0;
      tol_s  <= '0;
    end else if (rnd_state == RND_SNAP) begin
      freq_s <= freq;
      exp_s  <= expected;
      tol_s  <= tol;
    end
  end

  // Shared comparator; the 33-bit difference keeps the full unsigned range without overflow.
  logic [31:0] cur_freq, cur_exp;
  logic [32:0] diff, abs_diff;
  logic        in_win;

  assign cur_freq = freq_s[ch_idx];
  assign cur_exp  = exp_s[ch_idx];
  assign diff     = {1'b0, cur_freq} - {1'b0, cur_exp};
  assign abs_diff = diff[32] ? (~diff + 33'd1) : diff;
  assign in_win   = (cur_freq != 32'd0) && (abs_diff <= {1'b0, tol_s});

  ch_state_t       ch_state [NUM_CH];
  logic [CW-1:0]   run_cnt  [NUM_CH];
  logic [NUM_CH-1:0] run_pol;
  ch_state_t       cur_state, ch_next;
  logic [CW-1:0]   run_inc, run_next;
  logic            entered;

  assign cur_state = ch_state[ch_idx];
  assign run_inc   = (run_pol[ch_idx] == in_win) ? run_cnt[ch_idx] + CW'(1) : CW'(1);

  // run_pol records the polarity of the current run, so a polarity change restarts it at 1.
  always_comb begin
    ch_next  = cur_state;
    run_next = run_inc;
    entered  = 1'b0;
    case (cur_state)
      CH_UNKNOWN: begin
        if (in_win && run_inc >= GOOD_TH) begin
          ch_next  = CH_OK;
          run_next = '0;
        end else if (!in_win && run_inc >= BAD_TH) begin
          ch_next  = CH_FAULT;
          run_next = '0;
          entered  = 1'b1;
        end
      end
      CH_OK: begin
        if (in_win) run_next = '0;
        else if (run_inc >= BAD_TH) begin
          ch_next  = CH_FAULT;
          run_next = '0;
          entered  = 1'b1;
        end
      end
      CH_FAULT: begin
        if (!in_win) run_next = '0;
        else if (run_inc >= GOOD_TH) begin
          ch_next  = CH_OK;
          run_next = '0;
        end
      end
      default: begin
        ch_next  = CH_UNKNOWN;
        run_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state[i] <= CH_UNKNOWN;
        run_cnt[i]  <= '0;
      end
      run_pol <= '0;
    end else if (eval_en) begin
      ch_state[ch_idx] <= ch_next;
      run_cnt[ch_idx]  <= run_next;
      run_pol[ch_idx]  <= in_win;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ok[i] = (ch_state[i] == CH_OK);
  end

  logic [NUM_CH-1:0] set_vec;
  logic              round_fault;

  always_comb begin
    set_vec = '0;
    if (eval_en && entered) set_vec[ch_idx] = 1'b1;
  end

  // A fault entry in the same cycle as clear_faults must survive the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_sticky <= '0;
      round_fault  <= 1'b0;
      round_done   <= 1'b0;
      irq          <= 1'b0;
      all_ok       <= 1'b0;
    end else begin
      fault_sticky <= (clear_faults ? '0 : fault_sticky) | set_vec;
      if (rnd_state == RND_SNAP)   round_fault <= 1'b0;
      else if (eval_en && entered) round_fault <= 1'b1;
      round_done <= (rnd_state == RND_FIN);
      irq        <= (rnd_state == RND_FIN) && round_fault;
      all_ok     <= &ok;
    end
  end

`ifdef CLK_FREQ_GUARD_MINMAX_EN
  logic [NUM_CH-1:0][31:0] min_q, max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clear_faults) begin
      min_q <= '1;
      max_q <= '0;
    end else if (eval_en) begin
      if (cur_freq != 32'd0 && cur_freq < min_q[ch_idx]) min_q[ch_idx] <= cur_freq;
      if (cur_freq > max_q[ch_idx])                      max_q[ch_idx] <= cur_freq;
    end
  end

  assign freq_min = min_q;
  assign freq_max = max_q;
`else
  assign freq_min = '0;
  assign freq_max = '0;
`endif

endmodule

// File: tb/tb_clk_freq_guard.sv
// Scoreboard bench for clk_freq_guard: stimulus pushes per-round expectations, a monitor checks each round_done.
module tb_clk_freq_guard;

  localparam int NCH = 4;
  localparam int SP  = 16;
  localparam logic [31:0] NOM = 32'd125000000;
  localparam logic [31:0] IN  = 32'd125000500;
`ifdef CLK_FREQ_GUARD_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clear_faults = 1'b0;
  logic [NCH-1:0][31:0] freq, expected;
  logic [31:0] tol;
  logic [NCH-1:0] ok, fault_sticky;
  logic all_ok, irq, round_done;
  logic [NCH-1:0][31:0] freq_min, freq_max;

  always #5 clk = ~clk;

  clk_freq_guard #(
    .NUM_CH(NCH), .SAMPLE_PERIOD(SP), .GOOD_COUNT(3), .BAD_COUNT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freq(freq), .expected(expected),
    .tol(tol), .clear_faults(clear_faults), .ok(ok), .all_ok(all_ok),
    .fault_sticky(fault_sticky), .irq(irq), .round_done(round_done),
    .freq_min(freq_min), .freq_max(freq_max)
  );

  typedef struct {
    logic [3:0]  ok;
    logic [3:0]  sticky;
    logic        irq;
    logic        all_ok;
    logic [31:0] fmin;
    logic [31:0] fmax;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int checks = 0;
  int errors = 0;
  int rnd_no = 0;
  logic [31:0] mm_min, mm_max;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    mm_min = MINMAX ? 32'hFFFF_FFFF : 32'h0;
    mm_max = 32'h0;
  endtask

  // Drives one round of inputs and queues the hand-computed result for that round's round_done.
  task automatic applyStimulus(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                               input logic [31:0] f3, input logic [31:0] e, input logic [31:0] t,
                               input bit clr_in_round, input logic [3:0] exp_ok,
                               input logic [3:0] exp_sticky, input logic exp_irq);
    exp_t x;
    freq[0] = f0; freq[1] = f1; freq[2] = f2; freq[3] = f3;
    for (int i = 0; i < NCH; i++) expected[i] = e;
    tol = t;
    if (MINMAX) begin
      if (f0 != 0 && f0 < mm_min) mm_min = f0;
      if (f0 > mm_max) mm_max = f0;
      if (clr_in_round) begin
        mm_min = 32'hFFFF_FFFF;
        mm_max = 32'h0;
      end
    end
    x.ok = exp_ok;
    x.sticky = exp_sticky;
    x.irq = exp_irq;
    x.all_ok = &exp_ok;
    x.fmin = mm_min;
    x.fmax = mm_max;
    sb.push_back(x);
  endtask

  task automatic waitRound(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (round_done) found = 1'b1;
    end
    checkOutput({name, "_round_done_seen"}, {31'd0, found}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (irq && !round_done) checkOutput("irq_outside_round_done", 32'd1, 32'd0);
    if (round_done) begin
      rnd_no++;
      if (sb.size() == 0) begin
        checkOutput($sformatf("r%0d_unexpected_round_done", rnd_no), 32'd1, 32'd0);
      end else begin
        mon_x = sb.pop_front();
        checkOutput($sformatf("r%0d_ok", rnd_no), {28'd0, ok}, {28'd0, mon_x.ok});
        checkOutput($sformatf("r%0d_sticky", rnd_no), {28'd0, fault_sticky}, {28'd0, mon_x.sticky});
        checkOutput($sformatf("r%0d_irq", rnd_no), {31'd0, irq}, {31'd0, mon_x.irq});
        checkOutput($sformatf("r%0d_all_ok", rnd_no), {31'd0, all_ok}, {31'd0, mon_x.all_ok});
        checkOutput($sformatf("r%0d_freq_min0", rnd_no), freq_min[0], mon_x.fmin);
        checkOutput($sformatf("r%0d_freq_max0", rnd_no), freq_max[0], mon_x.fmax);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkReset();
    checkOutput("rst_ok", {28'd0, ok}, 32'd0);
    checkOutput("rst_all_ok", {31'd0, all_ok}, 32'd0);
    checkOutput("rst_sticky", {28'd0, fault_sticky}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_round_done", {31'd0, round_done}, 32'd0);
    checkOutput("rst_freq_min3", freq_min[3], MINMAX ? 32'hFFFF_FFFF : 32'h0);
    checkOutput("rst_freq_max3", freq_max[3], 32'h0);
  endtask

  initial begin
    int lat;
    int stray;
    freq = '0;
    expected = '0;
    tol = '0;
    enable = 1'b1;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkReset();

    // Phase A: nominal channels, then a step fault on ch2 and a boundary fault on ch3
    applyStimulus(IN, IN, IN, IN, NOM, 32'd1000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 64 && lat == 0; i++) begin
      @(negedge clk);
      if (round_done) lat = i;
    end
    checkOutput("first_round_latency", lat, SP + NCH + 3);

    applyStimulus(IN, IN, IN, IN, NOM, 32'd1000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    waitRound("r2");
    applyStimulus(IN, IN, IN, IN, NOM, 32'd1000, 1'b0, 4'b1111, 4'b0000, 1'b0);
    waitRound("r3");
    applyStimulus(IN, IN, 32'd124990000, IN, NOM, 32'd1000, 1'b0, 4'b1111, 4'b0000, 1'b0);
    waitRound("r4");
    applyStimulus(IN, IN, 32'd124990000, IN, NOM, 32'd1000, 1'b0, 4'b1011, 4'b0100, 1'b1);
    waitRound("r5");
    applyStimulus(IN, IN, IN, 32'd124998999, NOM, 32'd1000, 1'b0, 4'b1011, 4'b0100, 1'b0);
    waitRound("r6");
    // clear_faults lands on the cycle ch3 enters FAULT
    applyStimulus(32'd125001000, 32'd124999000, IN, 32'd124998999, NOM, 32'd1000, 1'b1,
                  4'b0011, 4'b1000, 1'b1);
    repeat (14) @(posedge clk);
    #1 clear_faults = 1'b1;
    @(posedge clk);
    #1 clear_faults = 1'b0;
    waitRound("r7");
    applyStimulus(IN, IN, IN, NOM, NOM, 32'd1000, 1'b0, 4'b0111, 4'b1000, 1'b0);
    waitRound("r8");
    applyStimulus(IN, IN, IN, 32'd0, NOM, 32'd1000, 1'b0, 4'b0111, 4'b1000, 1'b0);
    waitRound("r9");
    applyStimulus(IN, IN, IN, NOM, NOM, 32'd1000, 1'b0, 4'b0111, 4'b1000, 1'b0);
    waitRound("r10");
    applyStimulus(IN, IN, IN, NOM, NOM, 32'd1000, 1'b0, 4'b0111, 4'b1000, 1'b0);
    waitRound("r11");
    applyStimulus(IN, IN, IN, NOM, NOM, 32'd1000, 1'b0, 4'b1111, 4'b1000, 1'b0);
    waitRound("r12");

    // enable drops two cycles after the tick; the round in flight still finishes
    applyStimulus(IN, IN, IN, IN, NOM, 32'd1000, 1'b0, 4'b1111, 4'b1000, 1'b0);
    repeat (11) @(posedge clk);
    #1 enable = 1'b0;
    waitRound("r13");
    stray = 0;
    repeat (3 * SP) begin
      @(negedge clk);
      if (round_done) stray++;
    end
    checkOutput("no_round_while_disabled", stray, 0);
    checkOutput("hold_ok", {28'd0, ok}, 32'h0000000F);
    checkOutput("hold_sticky", {28'd0, fault_sticky}, 32'h00000008);

    // Phase B: zero-frequency and tolerance-edge channels
    rst_n = 1'b0;
    enable = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    checkReset();
    applyStimulus(32'd3, 32'd0, 32'd5, 32'd6, 32'd0, 32'd5, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitRound("b1");
    applyStimulus(32'd3, 32'd0, 32'd5, 32'd6, 32'd0, 32'd5, 1'b0, 4'b0000, 4'b1010, 1'b1);
    waitRound("b2");
    applyStimulus(32'd3, 32'd0, 32'd5, 32'd6, 32'd0, 32'd5, 1'b0, 4'b0101, 4'b1010, 1'b0);
    waitRound("b3");

`ifdef CLK_FREQ_GUARD_MINMAX_EN
    // Phase C: min/max tracking on ch0 ignores a zero sample for the minimum
    rst_n = 1'b0;
    resetModel();
    @(posedge clk);
    #1;
    applyStimulus(32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitRound("c1");
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 4'b1111, 1'b1);
    waitRound("c2");
    applyStimulus(32'd300, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 4'b1111, 1'b0);
    waitRound("c3");
    applyStimulus(32'd200, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 4'b1111, 1'b0);
    waitRound("c4");
    checkOutput("c4_min_value", freq_min[0], 32'd100);
    checkOutput("c4_max_value", freq_max[0], 32'd300);
    clear_faults = 1'b1;
    @(posedge clk);
    #1 clear_faults = 1'b0;
    checkOutput("clear_freq_min0", freq_min[0], 32'hFFFF_FFFF);
    checkOutput("clear_freq_max0", freq_max[0], 32'h0);
    checkOutput("clear_sticky", {28'd0, fault_sticky}, 32'h0);
`endif

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
